// File: rtl/muldiv_ctrl_if.sv
// Handshake and data bundle between a pipeline and the iterative multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] MulDivResult;

    modport master (
        output start, funct3, ReadData1, ReadData2, flush,
        input  busy, stall, done, MulDivResult
    );

    modport slave (
        input  start, funct3, ReadData1, ReadData2, flush,
        output busy, stall, done, MulDivResult
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit RISC-V M-extension unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, followed by a one-cycle sign-fix and result select.
module muldiv_ctrl #(
    parameter bit DIV0_SHORTCUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [5:0] LAST_STEP = 6'd31;

    logic [1:0]  state;
    logic [2:0]  op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        a_neg;
    logic        b_neg;
    logic        div0;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] result;

    // Request decode: signedness per operation, then sign and magnitude of each operand.
    logic        in_a_signed;
    logic        in_b_signed;
    logic        in_a_neg;
    logic        in_b_neg;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;
    logic        in_div0;
    logic [31:0] in_div0_result;

    // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        in_a_signed = 1'b0;
        in_b_signed = 1'b0;
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                in_a_signed = 1'b1;
                in_b_signed = 1'b1;
            end
            3'b010: begin
                in_a_signed = 1'b1;
            end
            default: begin
                in_a_signed = 1'b0;
                in_b_signed = 1'b0;
            end
        endcase
        in_a_neg       = in_a_signed & bus.ReadData1[31];
        in_b_neg       = in_b_signed & bus.ReadData2[31];
        in_a_mag       = in_a_neg ? (32'd0 - bus.ReadData1) : bus.ReadData1;
        in_b_mag       = in_b_neg ? (32'd0 - bus.ReadData2) : bus.ReadData2;
        in_div0        = bus.funct3[2] && (bus.ReadData2 == 32'd0);
        in_div0_result = bus.funct3[1] ? bus.ReadData1 : 32'hFFFF_FFFF;
    end

    // One iteration step. Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}.
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? a_mag : 32'd0)};
        div_trial = acc[63:31];
        div_diff  = div_trial - {1'b0, b_mag};
        div_ge    = (div_trial >= {1'b0, b_mag});
        if (op[2]) begin
            acc_step = {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc[30:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    // Sign correction and result select, used only in FIX. A zero divisor leaves the
    // dividend as the remainder on its own; only the quotient has to be forced.
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] fix_result;

    always_comb begin
        prod_fixed = (a_neg ^ b_neg) ? (64'd0 - acc) : acc;
        if (div0) begin
            quo_fixed = 32'hFFFF_FFFF;
        end else begin
            quo_fixed = (a_neg ^ b_neg) ? (32'd0 - acc[31:0]) : acc[31:0];
        end
        rem_fixed = a_neg ? (32'd0 - acc[63:32]) : acc[63:32];
        unique case (op)
            3'b000:                 fix_result = prod_fixed[31:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fixed[63:32];
            3'b100, 3'b101:         fix_result = quo_fixed;
            default:                fix_result = rem_fixed;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op     <= 3'd0;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            div0   <= 1'b0;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            result <= 32'd0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op    <= bus.funct3;
                        a_mag <= in_a_mag;
                        b_mag <= in_b_mag;
                        a_neg <= in_a_neg;
                        b_neg <= in_b_neg;
                        div0  <= in_div0;
                        cnt   <= 6'd0;
                        acc   <= {32'd0, (bus.funct3[2] ? in_a_mag : in_b_mag)};
                        if (DIV0_SHORTCUT && in_div0) begin
                            result <= in_div0_result;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result <= fix_result;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (state == ST_CALC) || (state == ST_FIX);
    assign bus.stall        = ((state == ST_IDLE) && bus.start) || bus.busy;
    assign bus.done         = (state == ST_DONE);
    assign bus.MulDivResult = result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: one instance with the divide-by-zero shortcut and one
// without, both fed the same inputs; sel picks which one an operation is observed on.
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus0 ();
    muldiv_ctrl_if bus1 ();

    muldiv_ctrl #(.DIV0_SHORTCUT(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    muldiv_ctrl #(.DIV0_SHORTCUT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.start     = bus0.start;
    assign bus1.funct3    = bus0.funct3;
    assign bus1.ReadData1 = bus0.ReadData1;
    assign bus1.ReadData2 = bus0.ReadData2;
    assign bus1.flush     = bus0.flush;

    logic        obs_done;
    logic        obs_stall;
    logic        obs_busy;
    logic [31:0] obs_result;
    assign obs_done   = sel ? bus1.done : bus0.done;
    assign obs_stall  = sel ? bus1.stall : bus0.stall;
    assign obs_busy   = sel ? bus1.busy : bus0.busy;
    assign obs_result = sel ? bus1.MulDivResult : bus0.MulDivResult;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; start is raised in the current cycle (cycle 0). A nonzero
    // poke re-asserts start with other operands in that cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected,
                          input int exp_lat, input int poke);
        int cyc;
        int stall_cnt;
        bit seen;
        bus0.start     = 1'b1;
        bus0.funct3    = f;
        bus0.ReadData1 = a;
        bus0.ReadData2 = b;
        #1;
        cyc = 0;
        stall_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            if (obs_stall) stall_cnt++;
            if (obs_done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                bus0.start = (cyc == poke);
                if (cyc == poke) begin
                    bus0.funct3    = 3'b011;
                    bus0.ReadData1 = 32'hFFFF_FFFF;
                    bus0.ReadData2 = 32'h0000_0000;
                end
                #1;
            end
        end
        bus0.start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, obs_result, expected);
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        @(negedge clk);
        check({tag, " done_single_pulse"}, 32'(obs_done), 32'd0);
        check({tag, " idle_after"}, 32'(obs_busy), 32'd0);
    endtask

    initial begin
        int dcount;
        bus0.start     = 1'b0;
        bus0.funct3    = 3'b000;
        bus0.ReadData1 = 32'd0;
        bus0.ReadData2 = 32'd0;
        bus0.flush     = 1'b0;

        #12;
        check("reset result", bus0.MulDivResult, 32'd0);
        check("reset busy", 32'(bus0.busy), 32'd0);
        check("reset done", 32'(bus0.done), 32'd0);
        check("reset stall idle", 32'(bus0.stall), 32'd0);
        bus0.start = 1'b1;
        #1;
        check("reset stall follows start", 32'(bus0.stall), 32'd1);
        bus0.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 12);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("mul carry", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34, 0);
        run_op("mulhu carry", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, 0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 20);
        run_op("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("div overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_op("rem overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        run_op("div neg", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 0);
        run_op("rem neg dividend", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 0);
        run_op("divu max", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
        run_op("div by zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem by zero", 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("remu by zero", 3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);

        // Flush at CALC cycle 10 with a competing start in the same cycle.
        bus0.start     = 1'b1;
        bus0.funct3    = 3'b000;
        bus0.ReadData1 = 32'd3;
        bus0.ReadData2 = 32'd5;
        repeat (10) begin
            @(negedge clk);
            bus0.start = 1'b0;
        end
        #1;
        check("flush busy before", 32'(bus0.busy), 32'd1);
        bus0.flush     = 1'b1;
        bus0.start     = 1'b1;
        bus0.funct3    = 3'b101;
        bus0.ReadData1 = 32'd100;
        bus0.ReadData2 = 32'd7;
        @(negedge clk);
        bus0.flush = 1'b0;
        bus0.start = 1'b0;
        #1;
        check("flush busy after", 32'(bus0.busy), 32'd0);
        check("flush result held", bus0.MulDivResult, 32'hFFFF_FFFB);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus0.done) dcount++;
        end
        check("flush no done", 32'(dcount), 32'd0);
        check("flush result still held", bus0.MulDivResult, 32'hFFFF_FFFB);
        run_op("divu after flush", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);

        // Reset pulse at CALC cycle 20.
        bus0.start     = 1'b1;
        bus0.funct3    = 3'b000;
        bus0.ReadData1 = 32'd3;
        bus0.ReadData2 = 32'd5;
        repeat (20) begin
            @(negedge clk);
            bus0.start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midop reset result", bus0.MulDivResult, 32'd0);
        check("midop reset busy", 32'(bus0.busy), 32'd0);
        check("midop reset done", 32'(bus0.done), 32'd0);
        check("midop reset stall", 32'(bus0.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus0.done) dcount++;
        end
        check("midop reset no done", 32'(dcount), 32'd0);
        run_op("mulhsu after reset", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34, 0);

        // Zero divisor on the instance without the shortcut: full-length path, forced result.
        repeat (40) @(negedge clk);
        sel = 1'b1;
        run_op("div by zero long", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 34, 0);
        run_op("rem by zero long", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34, 0);
        run_op("divu by zero long", 3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
